// File: rtl/bullet_scheduler.sv
// Sole owner of bullet RAM port A: clears the table, advances every live bullet
// once per frame tick, and places turret spawns into the first free slot.
module bullet_scheduler (
  input  logic        CLOCK_50,
  input  logic        resetn,
  input  logic        frame_tick,
  input  logic        clear_req,
  input  logic        spawn_req,
  input  logic [7:0]  spawn_x,
  input  logic [6:0]  spawn_y,
  input  logic [1:0]  spawn_dir,
  output logic        spawn_ack,
  output logic        spawn_drop,
  output logic [6:0]  bullet_addr,
  output logic [17:0] bullet_wdata,
  output logic        bullet_wren,
  input  logic [17:0] bullet_rdata,
  output logic        busy,
  output logic        walk_done,
  output logic        tick_overrun
);

  typedef enum logic [2:0] {IDLE, CLEAR, WALK_RD, WALK_WB, SPN_RD, SPN_CHK} state_t;

  state_t      state, state_nx;
  logic [6:0]  idx, idx_nx;
  logic [6:0]  ptr, ptr_nx;
  logic [6:0]  spawn_ptr, spawn_ptr_nx;
  logic [6:0]  probes, probes_nx;
  logic [6:0]  addr_nx;
  logic        tick_pend, tick_pend_nx;
  logic        clr_pend, clr_pend_nx;
  logic        ack_nx, drop_nx, done_nx, ovr_nx, busy_nx;
  logic        take_tick, take_clear;

  // One-pixel move; x is widened to 9 bits and y to 8 so a step below zero
  // shows up as a large value and falls into the same range test as overflow.
  function automatic logic [17:0] advance(input logic [17:0] e);
    logic [8:0] nx;
    logic [7:0] ny;
    nx = {1'b0, e[14:7]};
    ny = {1'b0, e[6:0]};
    case (e[16:15])
      2'd0:    nx = nx + 9'd1;
      2'd1:    nx = nx - 9'd1;
      2'd2:    ny = ny + 8'd1;
      default: ny = ny - 8'd1;
    endcase
    if (nx >= 9'd160 || ny >= 8'd120) advance = '0;
    else                              advance = {1'b1, e[16:15], nx[7:0], ny[6:0]};
  endfunction

  always_comb begin
    state_nx     = state;
    idx_nx       = idx;
    ptr_nx       = ptr;
    spawn_ptr_nx = spawn_ptr;
    probes_nx    = probes;
    addr_nx      = bullet_addr;
    ack_nx       = 1'b0;
    drop_nx      = 1'b0;
    done_nx      = 1'b0;
    take_tick    = 1'b0;
    take_clear   = 1'b0;
    case (state)
      IDLE: begin
        if (clr_pend) begin
          take_clear = 1'b1;
          state_nx   = CLEAR;
          idx_nx     = 7'd0;
          addr_nx    = 7'd0;
        end else if (tick_pend) begin
          take_tick = 1'b1;
          state_nx  = WALK_RD;
          idx_nx    = 7'd0;
          addr_nx   = 7'd0;
        end else if (spawn_req && !spawn_ack) begin
          // The ack cycle itself is ignored so a requester that drops right
          // after the ack is not mistaken for a fresh request.
          state_nx  = SPN_RD;
          ptr_nx    = spawn_ptr;
          probes_nx = 7'd0;
          addr_nx   = spawn_ptr;
        end
      end
      CLEAR: begin
        idx_nx  = idx + 7'd1;
        addr_nx = idx + 7'd1;
        if (idx == 7'd127) state_nx = IDLE;
      end
      WALK_RD: state_nx = WALK_WB;
      WALK_WB: begin
        idx_nx  = idx + 7'd1;
        addr_nx = idx + 7'd1;
        if (idx == 7'd127) begin
          state_nx = IDLE;
          done_nx  = 1'b1;
        end else begin
          state_nx = WALK_RD;
        end
      end
      SPN_RD: state_nx = SPN_CHK;
      SPN_CHK: begin
        if (!bullet_rdata[17]) begin
          ack_nx       = 1'b1;
          spawn_ptr_nx = ptr + 7'd1;
          state_nx     = IDLE;
        end else begin
          ptr_nx    = ptr + 7'd1;
          probes_nx = probes + 7'd1;
          addr_nx   = ptr + 7'd1;
          if (probes == 7'd127) begin
            ack_nx   = 1'b1;
            drop_nx  = 1'b1;
            state_nx = IDLE;
          end else begin
            state_nx = SPN_RD;
          end
        end
      end
      default: state_nx = IDLE;
    endcase

    busy_nx      = (state_nx != IDLE);
    clr_pend_nx  = clear_req | (clr_pend & ~take_clear);
    tick_pend_nx = frame_tick | (tick_pend & ~take_tick & ~take_clear);
    ovr_nx       = frame_tick & tick_pend & ~take_tick & ~take_clear;
  end

  // Write-back data depends on the word the RAM returns in this same cycle.
  always_comb begin
    bullet_wren  = 1'b0;
    bullet_wdata = '0;
    case (state)
      CLEAR: bullet_wren = 1'b1;
      WALK_WB: if (bullet_rdata[17]) begin
        bullet_wren  = 1'b1;
        bullet_wdata = advance(bullet_rdata);
      end
      SPN_CHK: if (!bullet_rdata[17]) begin
        bullet_wren  = 1'b1;
        bullet_wdata = {1'b1, spawn_dir, spawn_x, spawn_y};
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      idx          <= 7'd0;
      ptr          <= 7'd0;
      spawn_ptr    <= 7'd0;
      probes       <= 7'd0;
      tick_pend    <= 1'b0;
      clr_pend     <= 1'b0;
      bullet_addr  <= 7'd0;
      busy         <= 1'b0;
      spawn_ack    <= 1'b0;
      spawn_drop   <= 1'b0;
      walk_done    <= 1'b0;
      tick_overrun <= 1'b0;
    end else begin
      state        <= state_nx;
      idx          <= idx_nx;
      ptr          <= ptr_nx;
      spawn_ptr    <= spawn_ptr_nx;
      probes       <= probes_nx;
      tick_pend    <= tick_pend_nx;
      clr_pend     <= clr_pend_nx;
      bullet_addr  <= addr_nx;
      busy         <= busy_nx;
      spawn_ack    <= ack_nx;
      spawn_drop   <= drop_nx;
      walk_done    <= done_nx;
      tick_overrun <= ovr_nx;
    end
  end

endmodule

// File: tb/tb_bullet_scheduler.sv
// Bench for bullet_scheduler: RAM model on port A plus a table-level reference
// model of walks and spawns, exercised with directed and random steps.
module tb_bullet_scheduler;

  logic        clk;
  logic        resetn, frame_tick, clear_req, spawn_req;
  logic [7:0]  spawn_x;
  logic [6:0]  spawn_y;
  logic [1:0]  spawn_dir;
  logic        spawn_ack, spawn_drop, bullet_wren, busy, walk_done, tick_overrun;
  logic [6:0]  bullet_addr;
  logic [17:0] bullet_wdata, bullet_rdata;

  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [17:0] pre_data;
  logic [17:0] mem [128];
  logic [17:0] ref_mem [128];
  int          model_ptr;
  int          n_checks, n_fail;

  bullet_scheduler dut (
    .CLOCK_50(clk), .resetn(resetn), .frame_tick(frame_tick), .clear_req(clear_req),
    .spawn_req(spawn_req), .spawn_x(spawn_x), .spawn_y(spawn_y), .spawn_dir(spawn_dir),
    .spawn_ack(spawn_ack), .spawn_drop(spawn_drop), .bullet_addr(bullet_addr),
    .bullet_wdata(bullet_wdata), .bullet_wren(bullet_wren), .bullet_rdata(bullet_rdata),
    .busy(busy), .walk_done(walk_done), .tick_overrun(tick_overrun)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Registered-address RAM; the bench backdoor port only writes while the DUT is idle.
  always @(posedge clk) begin
    if (pre_we)           mem[pre_addr]    <= pre_data;
    else if (bullet_wren) mem[bullet_addr] <= bullet_wdata;
    bullet_rdata <= mem[bullet_addr];
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cmp_mem(input string tag);
    int bad;
    bad = 0;
    for (int i = 0; i < 128; i++) if (mem[i] !== ref_mem[i]) bad++;
    chk({tag, "_table_mismatches"}, bad, 0);
  endtask

  task automatic preload(input int a, input logic [17:0] d);
    pre_we = 1'b1; pre_addr = 7'(a); pre_data = d;
    step();
    pre_we = 1'b0;
    ref_mem[a] = d;
  endtask

  function automatic void model_walk();
    for (int i = 0; i < 128; i++) begin
      logic [17:0] e;
      int x, y, d;
      e = ref_mem[i];
      if (e[17]) begin
        x = int'(e[14:7]); y = int'(e[6:0]); d = int'(e[16:15]);
        if (d == 0) x = x + 1;
        if (d == 1) x = x - 1;
        if (d == 2) y = y + 1;
        if (d == 3) y = y - 1;
        if (x < 0 || x >= 160 || y < 0 || y >= 120) ref_mem[i] = '0;
        else ref_mem[i] = {1'b1, e[16:15], 8'(x), 7'(y)};
      end
    end
  endfunction

  // Returns the probe number that found a free slot, or 0 when the table is full.
  function automatic int model_spawn(input logic [7:0] x, input logic [6:0] y, input logic [1:0] d);
    for (int k = 0; k < 128; k++) begin
      int s;
      s = (model_ptr + k) % 128;
      if (!ref_mem[s][17]) begin
        ref_mem[s] = {1'b1, d, x, y};
        model_ptr = (s + 1) % 128;
        return k + 1;
      end
    end
    return 0;
  endfunction

  function automatic int edge_pick(input int m);
    case ($urandom_range(0, 3))
      0:       return 0;
      1:       return m;
      default: return int'($urandom_range(0, m));
    endcase
  endfunction

  function automatic logic [17:0] rand_entry();
    logic [1:0] d;
    d = 2'($urandom_range(0, 3));
    if ($urandom_range(0, 3) == 0) return {1'b0, 17'($urandom)};
    return {1'b1, d, 8'(edge_pick(159)), 7'(edge_pick(119))};
  endfunction

  // Steps until the DUT has been busy and returned to idle, recording what it did.
  task automatic watch(input int limit, output int nbusy, output int nwren, output int done_at,
                       output int ack_at, output bit drop, output int novr, output int nbad_clear);
    bit seen;
    int b0;
    nbusy = 0; nwren = 0; done_at = -1; ack_at = -1; drop = 0; novr = 0; nbad_clear = 0;
    seen = 0; b0 = 0;
    for (int t = 0; t < limit; t++) begin
      step();
      if (tick_overrun) novr++;
      if (busy && !seen) begin seen = 1; b0 = t; end
      if (busy) nbusy++;
      if (bullet_wren) begin
        if (bullet_wdata !== 18'h0 || bullet_addr !== 7'(nwren)) nbad_clear++;
        nwren++;
      end
      if (walk_done) done_at = t - b0;
      if (spawn_ack) begin ack_at = t - b0; drop = spawn_drop; end
      if (seen && !busy) break;
    end
    chk("operation_completes", longint'(seen && !busy), 1);
  endtask

  task automatic do_clear(input string tag, input bit with_tick);
    int nb, nw, dn, ak, nv, nbad;
    bit dr;
    clear_req = 1'b1; frame_tick = with_tick;
    step();
    clear_req = 1'b0; frame_tick = 1'b0;
    watch(400, nb, nw, dn, ak, dr, nv, nbad);
    for (int i = 0; i < 128; i++) ref_mem[i] = '0;
    chk({tag, "_busy_cycles"}, nb, 128);
    chk({tag, "_wren_cycles"}, nw, 128);
    chk({tag, "_addr_data_seq_errors"}, nbad, 0);
    chk({tag, "_no_walk"}, dn, -1);
    chk({tag, "_no_ack"}, ak, -1);
    for (int t = 0; t < 4; t++) begin
      step();
      chk({tag, "_stays_idle"}, busy, 0);
    end
    cmp_mem(tag);
  endtask

  task automatic do_walk(input string tag);
    int nb, nw, dn, ak, nv, nbad, nvalid;
    bit dr;
    nvalid = 0;
    for (int i = 0; i < 128; i++) if (ref_mem[i][17]) nvalid++;
    model_walk();
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    watch(700, nb, nw, dn, ak, dr, nv, nbad);
    chk({tag, "_walk_done_at"}, dn, 256);
    chk({tag, "_busy_cycles"}, nb, 256);
    chk({tag, "_wren_valid_only"}, nw, nvalid);
    chk({tag, "_overrun"}, nv, 0);
    cmp_mem(tag);
  endtask

  task automatic do_spawn(input string tag, input logic [7:0] x, input logic [6:0] y, input logic [1:0] d);
    int k, nb, nw, dn, ak, nv, nbad;
    bit dr;
    step();
    k = model_spawn(x, y, d);
    spawn_x = x; spawn_y = y; spawn_dir = d; spawn_req = 1'b1;
    watch(600, nb, nw, dn, ak, dr, nv, nbad);
    spawn_req = 1'b0;
    chk({tag, "_ack_at"}, ak, (k == 0) ? 256 : 2 * k);
    chk({tag, "_drop"}, dr, (k == 0) ? 1 : 0);
    chk({tag, "_wren_count"}, nw, (k == 0) ? 0 : 1);
    cmp_mem(tag);
  endtask

  initial begin
    int acks, ack_t, walks, ovr, wr_before, b0, nb;
    bit dr;
    n_checks = 0; n_fail = 0; model_ptr = 0;
    frame_tick = 0; clear_req = 0; spawn_req = 0;
    spawn_x = 0; spawn_y = 0; spawn_dir = 0;
    pre_we = 0; pre_addr = 0; pre_data = 0;
    resetn = 1'b1;
    #2 resetn = 1'b0;
    repeat (3) step();
    chk("rst_busy", busy, 0);
    chk("rst_addr", bullet_addr, 0);
    chk("rst_wdata", bullet_wdata, 0);
    chk("rst_wren", bullet_wren, 0);
    chk("rst_ack", spawn_ack, 0);
    chk("rst_drop", spawn_drop, 0);
    chk("rst_walk_done", walk_done, 0);
    chk("rst_overrun", tick_overrun, 0);
    resetn = 1'b1;
    step();

    do_clear("clear", 1'b0);

    do_spawn("spawn_first", 8'd12, 7'd34, 2'd1);
    chk("spawn_first_slot0", mem[0], {1'b1, 2'd1, 8'd12, 7'd34});
    do_spawn("spawn_second", 8'd12, 7'd34, 2'd1);
    chk("spawn_second_slot1", mem[1], {1'b1, 2'd1, 8'd12, 7'd34});

    preload(5, {1'b1, 2'd0, 8'd159, 7'd10});
    preload(6, {1'b1, 2'd3, 8'd20, 7'd0});
    preload(9, {1'b1, 2'd2, 8'd40, 7'd50});
    do_walk("walk_directed");
    chk("walk_entry5_retired", mem[5], 0);
    chk("walk_entry6_retired", mem[6], 0);
    chk("walk_entry9_moved", mem[9], {1'b1, 2'd2, 8'd40, 7'd51});

    for (int r = 0; r < 3; r++) begin
      for (int n = 0; n < 24; n++) preload(int'($urandom_range(0, 127)), rand_entry());
      do_walk("walk_random");
    end

    for (int n = 0; n < 8; n++)
      do_spawn("spawn_random", 8'($urandom_range(0, 159)), 7'($urandom_range(0, 119)),
               2'($urandom_range(0, 3)));

    do_clear("clear_with_tick", 1'b1);

    for (int i = 0; i < 128; i++)
      preload(i, {1'b1, 2'($urandom_range(0, 3)), 8'(edge_pick(159)), 7'(edge_pick(119))});
    do_spawn("spawn_full", 8'd1, 7'd2, 2'd0);

    // Full-table search with two ticks arriving during it.
    step();
    acks = 0; ack_t = -1; walks = 0; ovr = 0; wr_before = 0; b0 = -1; dr = 0;
    spawn_x = 8'd3; spawn_y = 7'd4; spawn_dir = 2'd2; spawn_req = 1'b1;
    for (int t = 0; t < 700; t++) begin
      frame_tick = (t == 10 || t == 30);
      step();
      frame_tick = 1'b0;
      if (busy && b0 < 0) b0 = t;
      if (tick_overrun) ovr++;
      if (walk_done) walks++;
      if (bullet_wren && acks == 0) wr_before++;
      if (spawn_ack) begin acks++; ack_t = t - b0; dr = spawn_drop; spawn_req = 1'b0; end
    end
    model_walk();
    chk("ovr_spawn_acks", acks, 1);
    chk("ovr_spawn_ack_at", ack_t, 256);
    chk("ovr_spawn_drop", dr, 1);
    chk("ovr_no_write_in_search", wr_before, 0);
    chk("ovr_pulse_count", ovr, 1);
    chk("ovr_walk_count", walks, 1);
    cmp_mem("ovr_walk");

    // Reset in the middle of a walk.
    frame_tick = 1'b1;
    step();
    frame_tick = 1'b0;
    repeat (40) step();
    chk("midwalk_busy_before", busy, 1);
    #3 resetn = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_addr", bullet_addr, 0);
    chk("async_rst_wdata", bullet_wdata, 0);
    chk("async_rst_wren", bullet_wren, 0);
    chk("async_rst_ack", spawn_ack, 0);
    chk("async_rst_drop", spawn_drop, 0);
    chk("async_rst_walk_done", walk_done, 0);
    chk("async_rst_overrun", tick_overrun, 0);
    step();
    chk("rst_busy_next_edge", busy, 0);
    resetn = 1'b1;
    nb = 0;
    for (int t = 0; t < 20; t++) begin
      step();
      if (busy) nb++;
    end
    chk("post_rst_idle", nb, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
